mul_div: RTL and testbench

MUL_DIV -- requirements
Module: mul_div

---
 rtl/mul_div.sv | 165 ++++++++++++++++
 tb/tb_mul_div.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div.sv
// mul_div: iterative 32-bit multiply/divide unit producing HI/LO.
// Multiply uses shift-add and divide uses restoring shift-subtract.
// Both run on operand magnitudes with sign fix-up at completion.
// Each operation takes 32 iterations, one per clock cycle.
module mul_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;

    // Operands and operation captured at the start edge.
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    logic [1:0]  op_lat;

    // Working registers: partial product or remainder/quotient.
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    // Magnitudes of the latched operands.
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Magnitudes of the live inputs, used to seed the working registers.
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;

    // One-iteration next values.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] w_hi_n;
    logic [31:0] w_lo_n;
    logic        last;

    // Final results with sign correction applied.
    logic [63:0] prod;
    logic [63:0] mul_res;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_div   = op_lat[1];
    assign a_neg    = op_lat[0] & a_lat[31];
    assign b_neg    = op_lat[0] & b_lat[31];
    assign a_mag    = a_neg ? (~a_lat + 32'd1) : a_lat;
    assign b_mag    = b_neg ? (~b_lat + 32'd1) : b_lat;
    assign in_a_mag = (Op[0] & A[31]) ? (~A + 32'd1) : A;
    assign in_b_mag = (Op[0] & B[31]) ? (~B + 32'd1) : B;
    assign last     = (cnt == 5'd31);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Single iteration step plus final sign fix-up of the result.
    always_comb begin
        mul_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, a_mag} : 33'd0);
        div_shift = {w_hi, w_lo[31]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        if (is_div) begin
            w_hi_n = div_ge ? (div_shift[31:0] - b_mag) : div_shift[31:0];
            w_lo_n = {w_lo[30:0], div_ge};
        end else begin
            w_hi_n = mul_sum[32:1];
            w_lo_n = {mul_sum[0], w_lo[31:1]};
        end

        prod    = {w_hi_n, w_lo_n};
        mul_res = (a_neg ^ b_neg) ? (~prod + 64'd1) : prod;
        quo     = (a_neg ^ b_neg) ? (~w_lo_n + 32'd1) : w_lo_n;
        rem     = a_neg ? (~w_hi_n + 32'd1) : w_hi_n;

        if (!is_div) begin
            res_hi = mul_res[63:32];
            res_lo = mul_res[31:0];
        end else if (b_lat == '0) begin
            // Divide by zero bypasses sign fix-up so HI returns the raw dividend.
            res_hi = a_lat;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Operand capture, iteration datapath, and HI/LO result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            op_lat <= '0;
            w_hi   <= '0;
            w_lo   <= '0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat  <= A;
                        b_lat  <= B;
                        op_lat <= Op;
                        cnt    <= '0;
                        w_hi   <= '0;
                        w_lo   <= Op[1] ? in_a_mag : in_b_mag;
                    end
                end
                RUN: begin
                    w_hi <= w_hi_n;
                    w_lo <= w_lo_n;
                    cnt  <= cnt + 5'd1;
                    if (last) begin
                        HI <= res_hi;
                        LO <= res_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: directed vectors for mul_div with a queue-based scoreboard.
module tb_mul_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mul_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on each done pulse; checks HI/LO hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result_hi", {32'd0, HI}, {32'd0, e.hi});
                    check("result_lo", {32'd0, LO}, {32'd0, e.lo});
                    check("done_cycle", {32'd0, cyc}, {32'd0, e.cyc});
                end
            end else if (HI !== prev_hi || LO !== prev_lo) begin
                check("hilo_hold", {HI, LO}, {prev_hi, prev_lo});
            end
        end
        prev_hi = HI;
        prev_lo = LO;
    end

    // Wait (bounded) for done; caller is at a falling edge.
    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    // Issue one operation at the current falling edge and follow it to completion.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_t e;
        start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        e.cyc = cyc + 33;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        Op    = ~op;
        A     = $urandom;
        B     = $urandom;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        wait_done();
        check("busy_in_done", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("done_idle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        exp_t e;
        cyc     = 0;
        n_cmp   = 0;
        n_err   = 0;
        prev_hi = '0;
        prev_lo = '0;
        rst_n   = 1'b0;
        start   = 1'b0;
        Op      = 2'b00;
        A       = '0;
        B       = '0;

        #1;
        check("reset_hi", {32'd0, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op(2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        run_op(2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,        32'd6);
        run_op(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op(2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0);
        run_op(2'b11, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF);
        run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0);

        // A second start while busy must be ignored: 3*4 result, single done.
        start = 1'b1;
        Op    = 2'b00;
        A     = 32'd3;
        B     = 32'd4;
        e.hi  = 32'd0;
        e.lo  = 32'd12;
        e.cyc = cyc + 33;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        Op    = 2'b10;
        A     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("busy_after_ignored", {63'd0, busy}, 64'd0);

        // Reset mid-operation aborts: outputs clear at once, no done follows.
        start = 1'b1;
        Op    = 2'b00;
        A     = 32'hFFFFFFFF;
        B     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_hilo_stay_zero", {HI, LO}, 64'd0);

        // First start after reset is accepted normally.
        run_op(2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);

        check("scoreboard_empty", {32'd0, sb_q.size()}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
